mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, fixed-latency memory between the instruction-fetch port and the load/store data port.
//  Sits between the fetch/MEM stages and the unified memory; ControlUnit MemRead/MemWrite drive the data request.
//  Data port has priority (older instruction); a streak limit guarantees fetch progress. Stall outputs freeze the pipeline.
// PARAMETERS
//  ADDR_W        32  address width (byte address, passed through unchanged)
//  DATA_W        32  data width
//  MEM_LAT        2  memory read latency in cycles from mem_en sample to valid mem_rdata (legal 1..15)
//  MAX_D_STREAK   4  max consecutive data grants while if_req is pending (legal 1..15)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  if_req     in   1       fetch request; held high until if_ready
//  if_addr    in   ADDR_W  fetch address
//  if_rdata   out  DATA_W  fetched word, valid when if_ready=1
//  if_ready   out  1       one-cycle completion pulse to fetch
//  if_stall   out  1       if_req & ~if_ready
//  d_req      in   1       data request (MemRead|MemWrite); held until d_ready
//  d_we       in   1       1=store, 0=load
//  d_be       in   4       store byte enables
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_rdata    out  DATA_W  load data, valid when d_ready=1
//  d_ready    out  1       one-cycle completion pulse to data port
//  d_stall    out  1       d_req & ~d_ready
//  mem_en     out  1       memory access strobe, exactly one cycle per access
//  mem_we     out  1       memory write enable (qualified by mem_en)
//  mem_be     out  4       memory byte enables
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; all mem_*, *_ready, *_rdata, owner, lat_cnt, streak=0. In-flight access dropped, no ready.
//  - FSM IDLE->ISSUE->WAIT->DONE->IDLE. Arbitration only in IDLE; DONE->IDLE unconditional.
//  - IDLE: when any req is high at the clock edge, latch owner and its addr/we/be/wdata, go to ISSUE. Neither req high: stay.
//  - Winner: d_req only->data; if_req only->fetch; both->data, unless streak==MAX_D_STREAK, then fetch.
//  - streak: +1 on each data grant while if_req is high; cleared on fetch grant or when data is granted with if_req low; saturates.
//  - ISSUE (1 cycle): registered mem_en=1, mem_* = latched values; mem_we=1 only for data store; lat_cnt=MEM_LAT-1.
//  - WAIT: decrement lat_cnt each cycle; at lat_cnt==0, capture mem_rdata into owner's rdata reg (loads/fetches only), go DONE.
//    With MEM_LAT=1, WAIT lasts one cycle. mem_en=0 throughout WAIT/DONE.
//  - DONE (1 cycle): owner's ready=1. Store: d_rdata keeps previous value.
//  - Latency: req sampled at edge E -> mem_en high in cycle E+1 -> ready high in cycle E+MEM_LAT+2. Throughput: one access per MEM_LAT+3 cycles.
//  - Requesters see ready at the next edge; a req still high in the following IDLE cycle is a new access.
//  - rdata regs hold value until next capture for that port; ready never high on both ports simultaneously.
//  - Latched request is immune to req/addr changes after the grant edge; req drop mid-access does not abort.
//  - Stall outputs combinational from req and ready; all other outputs registered.
// TESTING (MEM_LAT=2, MAX_D_STREAK=4 unless stated)
//  1 Fetch only, if_addr=0x10, mem[0x10]=0x00500093 -> mem_en one cycle, mem_addr=0x10, mem_we=0; if_ready at E+4, if_rdata=0x00500093.
//  2 if_req and d_req (load 0x40, mem=0x12345678) in same IDLE -> data first, d_rdata=0x12345678; fetch granted next; if_stall high throughout.
//  3 Store d_addr=0x20, d_wdata=0xDEADBEEF, d_be=4'hF -> mem_we=1 one cycle; d_ready at E+4; next load 0x20 -> 0xDEADBEEF.
//  4 d_req and if_req held high continuously -> grant pattern D,D,D,D,F repeating; no two ready pulses overlap.
//  5 rst asserted during WAIT -> outputs 0 immediately, no ready; after release, held if_req reissued from IDLE with full latency.
//  6 MEM_LAT=1 build: fetch ready at E+3 with correct data; back-to-back fetches every 4 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency, single-ported memory between the fetch port and the load/store port.
// Data requests win by default; a bounded data streak guarantees that fetch keeps making progress.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LAT      = 2,
   parameter int MAX_D_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   output logic              if_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_be,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              d_stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
   localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

   state_t     state;
   state_t     state_nxt;

   logic       grant_d;
   logic       grant_f;
   logic       capture;
   logic       owner_d;
   logic       lat_we;
   logic [3:0] lat_cnt;
   logic [3:0] lat_cnt_nxt;
   logic [3:0] streak;
   logic [3:0] streak_nxt;
   logic       mem_en_nxt;
   logic       mem_we_nxt;
   logic       if_ready_nxt;
   logic       d_ready_nxt;

   assign if_stall = if_req & ~if_ready;
   assign d_stall  = d_req & ~d_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (d_req || if_req) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (lat_cnt == 4'd0) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Arbitration happens only in IDLE; the streak cap hands one slot to a waiting fetch.
   always_comb begin
      grant_d = 1'b0;
      grant_f = 1'b0;
      if (state == S_IDLE) begin
         if (d_req && if_req) begin
            if (streak == STREAK_MAX) grant_f = 1'b1;
            else                      grant_d = 1'b1;
         end else if (d_req) begin
            grant_d = 1'b1;
         end else if (if_req) begin
            grant_f = 1'b1;
         end
      end
   end

   always_comb begin
      capture      = (state == S_WAIT) && (lat_cnt == 4'd0);
      mem_en_nxt   = grant_d | grant_f;
      mem_we_nxt   = grant_d & d_we;
      if_ready_nxt = capture & ~owner_d;
      d_ready_nxt  = capture & owner_d;

      lat_cnt_nxt = lat_cnt;
      if (state == S_ISSUE) begin
         lat_cnt_nxt = LAT_INIT;
      end else if ((state == S_WAIT) && (lat_cnt != 4'd0)) begin
         lat_cnt_nxt = lat_cnt - 4'd1;
      end

      streak_nxt = streak;
      if (grant_f) begin
         streak_nxt = 4'd0;
      end else if (grant_d) begin
         if (!if_req)                   streak_nxt = 4'd0;
         else if (streak != STREAK_MAX) streak_nxt = streak + 4'd1;
      end
   end

   // The mem_* registers double as the latched request for the whole access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         owner_d   <= 1'b0;
         lat_we    <= 1'b0;
         lat_cnt   <= '0;
         streak    <= '0;
         if_ready  <= 1'b0;
         d_ready   <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         mem_en   <= mem_en_nxt;
         mem_we   <= mem_we_nxt;
         lat_cnt  <= lat_cnt_nxt;
         streak   <= streak_nxt;
         if_ready <= if_ready_nxt;
         d_ready  <= d_ready_nxt;

         if (grant_d) begin
            mem_be    <= d_be;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            owner_d   <= 1'b1;
            lat_we    <= d_we;
         end else if (grant_f) begin
            mem_be    <= 4'hF;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            owner_d   <= 1'b0;
            lat_we    <= 1'b0;
         end

         // Stores complete without touching d_rdata.
         if (capture) begin
            if (!owner_d)     if_rdata <= mem_rdata;
            else if (!lat_we) d_rdata  <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a MEM_LAT=2 instance for the main scenarios and a MEM_LAT=1 instance
// for single-cycle-latency fetch timing, both checked against a bench-side scoreboard.
module tb_mem_port_arbiter;

   localparam int LAT0 = 2;
   localparam int LAT1 = 1;

   logic        clk = 1'b0;
   logic        rst;

   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [3:0]  d_be;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        if_ready, if_stall, d_ready, d_stall, mem_en, mem_we;
   logic [3:0]  mem_be;

   logic        if_req1, d_req1, d_we1;
   logic [31:0] if_addr1, d_addr1, d_wdata1;
   logic [3:0]  d_be1;
   logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic        if_ready1, if_stall1, d_ready1, d_stall1, mem_en1, mem_we1;
   logic [3:0]  mem_be1;

   typedef struct {
      logic        is_d;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic        is_d;
      logic [31:0] data;
   } sb_t;

   sb_t  sb0[$];
   sb_t  sb1[$];
   vec_t vecs[7];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   logic [31:0] mem [0:63];
   bit          mem_loaded = 1'b0;
   logic [31:0] rd0_a, rd0_b, rd1_a;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT0), .MAX_D_STREAK(4)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT1), .MAX_D_STREAK(4)) u_dut1 (
      .clk(clk), .rst(rst),
      .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1), .if_stall(if_stall1),
      .d_req(d_req1), .d_we(d_we1), .d_be(d_be1), .d_addr(d_addr1), .d_wdata(d_wdata1),
      .d_rdata(d_rdata1), .d_ready(d_ready1), .d_stall(d_stall1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_be(mem_be1), .mem_addr(mem_addr1),
      .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
   );

   // Memory model: contents loaded on the first edge, byte-enabled writes, LAT-deep read pipes.
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         mem[6'h04] <= 32'h00500093;
         mem[6'h05] <= 32'h00A00113;
         mem[6'h06] <= 32'h00C00193;
         mem[6'h09] <= 32'h11223344;
         mem[6'h10] <= 32'h12345678;
         mem_loaded <= 1'b1;
      end else if (mem_en && mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      rd0_a <= mem_en  ? mem[mem_addr[7:2]]  : 32'hBAD0BAD0;
      rd0_b <= rd0_a;
      rd1_a <= mem_en1 ? mem[mem_addr1[7:2]] : 32'hBAD1BAD1;
   end
   assign mem_rdata  = rd0_b;
   assign mem_rdata1 = rd1_a;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboards: every ready pulse must match the next expected completion.
   always @(negedge clk) begin
      check("if_stall", 32'(if_stall), 32'(if_req & ~if_ready));
      check("d_stall", 32'(d_stall), 32'(d_req & ~d_ready));
      check("ready_overlap", 32'(if_ready & d_ready), 32'h0);
      if (if_ready || d_ready) begin
         if (sb0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb0_unexpected_ready: got if_ready=%b d_ready=%b, expected none", if_ready, d_ready);
         end else begin
            sb_t e;
            e = sb0.pop_front();
            check("sb0_port", 32'(d_ready), 32'(e.is_d));
            check("sb0_rdata", d_ready ? d_rdata : if_rdata, e.data);
         end
      end
   end

   always @(negedge clk) begin
      check("if_stall1", 32'(if_stall1), 32'(if_req1 & ~if_ready1));
      check("d_stall1", 32'(d_stall1), 32'(d_req1 & ~d_ready1));
      if (if_ready1 || d_ready1) begin
         if (sb1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb1_unexpected_ready: got if_ready1=%b d_ready1=%b, expected none", if_ready1, d_ready1);
         end else begin
            sb_t e;
            e = sb1.pop_front();
            check("sb1_port", 32'(d_ready1), 32'(e.is_d));
            check("sb1_rdata", if_rdata1, e.data);
         end
      end
   end

   // Waits (bounded) for the next ready pulse on one instance; port 1=data, 0=fetch.
   task automatic wait_rdy(input bit which, output int port, output int at);
      int  n;
      bit  found;
      n = 0;
      found = 1'b0;
      port = -1;
      at = -1;
      while (n < 30 && !found) begin
         @(negedge clk);
         n++;
         if (which == 1'b0 ? (if_ready | d_ready) : (if_ready1 | d_ready1)) begin
            found = 1'b1;
            port = (which == 1'b0) ? int'(d_ready) : int'(d_ready1);
            at = cyc;
         end
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got no ready in 30 cycles, expected one (dut %0d)", which);
      end
   endtask

   // Single isolated access on the MEM_LAT=2 instance; starts just after an edge with the DUT idle.
   task automatic op(input vec_t v);
      int k, port, t;
      k = cyc;
      if (v.is_d) begin
         d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      sb0.push_back('{is_d: v.is_d, data: v.exp});
      @(negedge clk);
      check("mem_en_pre", 32'(mem_en), 32'h0);
      @(negedge clk);
      check("mem_en_issue", 32'(mem_en), 32'h1);
      check("mem_addr", mem_addr, v.addr);
      check("mem_we", 32'(mem_we), 32'(v.is_d & v.we));
      if (v.is_d && v.we) begin
         check("mem_be", 32'(mem_be), 32'(v.be));
         check("mem_wdata", mem_wdata, v.wdata);
      end
      d_addr = ~v.addr; if_addr = ~v.addr; d_we = ~v.we; d_wdata = 32'h5A5A5A5A;
      @(negedge clk);
      check("mem_en_wait", 32'(mem_en), 32'h0);
      wait_rdy(1'b0, port, t);
      check("latency", 32'(t - k), 32'(LAT0 + 2));
      check("port", 32'(port), 32'(v.is_d));
      @(posedge clk); #1;
      d_req = 1'b0; if_req = 1'b0;
   endtask

   initial begin
      int          k, t, prev, port;
      logic [31:0] last_d;

      vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h10, 32'h0,        32'h00500093};
      vecs[1] = '{1'b1, 1'b1, 4'hF, 32'h20, 32'hDEADBEEF, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 4'h0, 32'h20, 32'h0,        32'hDEADBEEF};
      vecs[3] = '{1'b1, 1'b1, 4'h5, 32'h24, 32'hAABBCCDD, 32'h0};
      vecs[4] = '{1'b1, 1'b0, 4'h0, 32'h24, 32'h0,        32'h11BB33DD};
      vecs[5] = '{1'b1, 1'b0, 4'h0, 32'h40, 32'h0,        32'h12345678};
      vecs[6] = '{1'b0, 1'b0, 4'h0, 32'h14, 32'h0,        32'h00A00113};

      rst = 1'b1;
      if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
      if_req1 = 1'b0; if_addr1 = '0; d_req1 = 1'b0; d_we1 = 1'b0; d_be1 = '0; d_addr1 = '0; d_wdata1 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_en", 32'(mem_en), 32'h0);
      check("rst_mem_we", 32'(mem_we), 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_if_ready", 32'(if_ready), 32'h0);
      check("rst_d_ready", 32'(d_ready), 32'h0);
      check("rst_if_rdata", if_rdata, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);
      check("rst_mem_en1", 32'(mem_en1), 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Isolated accesses: fetch, store/load round-trips, partial store, plain loads.
      last_d = 32'h0;
      for (int i = 0; i < 7; i++) begin
         vec_t v;
         v = vecs[i];
         if (v.is_d && v.we) v.exp = last_d;
         else if (v.is_d)    last_d = v.exp;
         op(v);
      end

      // Simultaneous requests: data first, fetch in the following slot.
      k = cyc;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'h0;
      if_req = 1'b1; if_addr = 32'h10;
      sb0.push_back('{is_d: 1'b1, data: 32'h12345678});
      sb0.push_back('{is_d: 1'b0, data: 32'h00500093});
      wait_rdy(1'b0, port, t);
      check("both_first_port", 32'(port), 32'h1);
      check("both_first_lat", 32'(t - k), 32'(LAT0 + 2));
      @(posedge clk); #1;
      d_req = 1'b0;
      wait_rdy(1'b0, port, t);
      check("both_second_port", 32'(port), 32'h0);
      check("both_second_lat", 32'(t - k), 32'(2 * LAT0 + 5));
      @(posedge clk); #1;
      if_req = 1'b0;

      // Both held: four data grants then one fetch, repeating.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      if_req = 1'b1; if_addr = 32'h10;
      for (int i = 0; i < 10; i++) begin
         if (i % 5 == 4) sb0.push_back('{is_d: 1'b0, data: 32'h00500093});
         else            sb0.push_back('{is_d: 1'b1, data: 32'h12345678});
      end
      prev = -1;
      for (int i = 0; i < 10; i++) begin
         wait_rdy(1'b0, port, t);
         check("streak_port", 32'(port), (i % 5 == 4) ? 32'h0 : 32'h1);
         if (prev >= 0) check("streak_interval", 32'(t - prev), 32'(LAT0 + 3));
         prev = t;
      end
      @(posedge clk); #1;
      d_req = 1'b0; if_req = 1'b0;
      @(posedge clk); #1;

      // Reset during WAIT drops the access; the held fetch reissues with full latency.
      if_req = 1'b1; if_addr = 32'h18;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("wrst_mem_en", 32'(mem_en), 32'h0);
      check("wrst_mem_addr", mem_addr, 32'h0);
      check("wrst_if_ready", 32'(if_ready), 32'h0);
      check("wrst_d_rdata", d_rdata, 32'h0);
      check("wrst_if_rdata", if_rdata, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      k = cyc;
      sb0.push_back('{is_d: 1'b0, data: 32'h00C00193});
      wait_rdy(1'b0, port, t);
      check("wrst_reissue_lat", 32'(t - k), 32'(LAT0 + 2));
      check("wrst_reissue_port", 32'(port), 32'h0);
      @(posedge clk); #1;
      if_req = 1'b0;

      // MEM_LAT=1 instance: fetch latency and back-to-back fetch spacing.
      k = cyc;
      if_req1 = 1'b1; if_addr1 = 32'h10;
      sb1.push_back('{is_d: 1'b0, data: 32'h00500093});
      wait_rdy(1'b1, port, t);
      check("lat1_latency", 32'(t - k), 32'(LAT1 + 2));
      prev = t;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         if_addr1 = (i == 0) ? 32'h14 : 32'h18;
         sb1.push_back('{is_d: 1'b0, data: (i == 0) ? 32'h00A00113 : 32'h00C00193});
         wait_rdy(1'b1, port, t);
         check("lat1_interval", 32'(t - prev), 32'(LAT1 + 3));
         prev = t;
      end
      @(posedge clk); #1;
      if_req1 = 1'b0;

      repeat (6) @(posedge clk);
      #1;
      check("sb0_drained", 32'(sb0.size()), 32'h0);
      check("sb1_drained", 32'(sb1.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected finish earlier");
      $fatal(1, "watchdog expired");
   end

endmodule
